// File: rtl/drp_pkg.sv
// drp_pkg: shared definitions for the DRP initiator.
//   - drp_state_e : FSM state encoding (RMW states exist only with DRP_RMW_EN)
//   - DRP_*_DEF   : default widths and timeout
//   - drp_cnt_width() : timeout counter width for a given TIMEOUT
// Optional feature macro: DRP_RMW_EN (masked writes become read-modify-write).
package drp_pkg;

  localparam int DRP_ADDR_WIDTH_DEF = 16;
  localparam int DRP_DATA_WIDTH_DEF = 16;
  localparam int DRP_TIMEOUT_DEF    = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_ACCESS   = 3'd2,
    ST_WAIT     = 3'd3,
    ST_RESP     = 3'd4
`ifdef DRP_RMW_EN
    ,
    ST_ACCESS_W = 3'd5,
    ST_WAIT_W   = 3'd6
`endif
  } drp_state_e;

  // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  function automatic int drp_cnt_width(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/drp_timeout_cnt.sv
// drp_timeout_cnt: up-counter shared by the grant wait and the drdy wait.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clr       : synchronous clear (has priority over i_en)
//   i_en        : count enable
//   o_expired   : count has reached TIMEOUT-1
module drp_timeout_cnt
  import drp_pkg::*;
#(
  parameter int TIMEOUT = DRP_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = drp_cnt_width(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic             w_expired;

  assign w_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign o_expired = w_expired;

  // Holds at TIMEOUT-1 so an unserviced expiry can never wrap to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_expired) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/drp_master_ctrl.sv
// drp_master_ctrl: single-outstanding DRP initiator for the PCS/PMA shared core.
// Turns one command (read/write) into a req/gnt-arbitrated DRP access, waits a
// bounded time for grant and drdy, and returns data or a timeout flag.
// Ports:
//   cmd_*  : command channel (valid/ready), write flag, address, data, mask
//   rsp_*  : response channel (valid/ready), read data, timeout flag
//   drp_*  : DRP master side (req/gnt, den/dwe/daddr/di, drdy/drpdo)
// Optional feature macro: DRP_RMW_EN -- a write with nonzero cmd_mask is done as
// read-modify-write under one continuous drp_req; otherwise cmd_mask is ignored.
//
// state    | meaning
// IDLE     | cmd_ready high, waiting for a command
// REQ      | drp_req high, waiting for drp_gnt (bounded)
// ACCESS   | one-cycle den strobe (read phase for RMW)
// WAIT     | waiting for drdy (bounded)
// ACCESS_W | RMW only: one-cycle den strobe writing the merged word
// WAIT_W   | RMW only: waiting for drdy of the write phase
// RESP     | rsp_valid high until rsp_ready
module drp_master_ctrl
  import drp_pkg::*;
#(
  parameter int ADDR_WIDTH = DRP_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DRP_DATA_WIDTH_DEF,
  parameter int TIMEOUT    = DRP_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  drp_req,
  input  logic                  drp_gnt,
  output logic                  drp_den,
  output logic                  drp_dwe,
  output logic [ADDR_WIDTH-1:0] drp_daddr,
  output logic [DATA_WIDTH-1:0] drp_di,
  input  logic                  drp_drdy,
  input  logic [DATA_WIDTH-1:0] drp_drpdo
);

  drp_state_e            r_state;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_timeout;
  logic                  r_req;
  logic                  r_den;
  logic                  r_dwe;
  logic [ADDR_WIDTH-1:0] r_daddr;
  logic [DATA_WIDTH-1:0] r_di;
  logic                  w_cnt_en;
  logic                  w_expired;

`ifdef DRP_RMW_EN
  logic [DATA_WIDTH-1:0] r_mask;
  logic                  r_rmw;
  assign w_cnt_en = (r_state == ST_REQ) || (r_state == ST_WAIT) || (r_state == ST_WAIT_W);
`else
  // Mask has no meaning without read-modify-write support.
  logic w_unused_mask;
  assign w_unused_mask = ^cmd_mask;
  assign w_cnt_en = (r_state == ST_REQ) || (r_state == ST_WAIT);
`endif

  // Counter is held at zero in every non-waiting state, so each wait phase
  // (grant, read drdy, write drdy) starts from a fresh count.
  drp_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (!w_cnt_en),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;
  assign drp_req     = r_req;
  assign drp_den     = r_den;
  assign drp_dwe     = r_dwe;
  assign drp_daddr   = r_daddr;
  assign drp_di      = r_di;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
      r_req         <= 1'b0;
      r_den         <= 1'b0;
      r_dwe         <= 1'b0;
      r_daddr       <= '0;
      r_di          <= '0;
`ifdef DRP_RMW_EN
      r_mask        <= '0;
      r_rmw         <= 1'b0;
`endif
    end else begin
      // den/dwe/di are strobes: only the cycle entering an access sets them.
      r_den <= 1'b0;
      r_dwe <= 1'b0;
      r_di  <= '0;
      case (r_state)
        ST_IDLE: begin
          // cmd_ready is 0 for the first cycle after reset; no accept then.
          if (r_cmd_ready && cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_write     <= cmd_write;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
`ifdef DRP_RMW_EN
            r_mask      <= cmd_mask;
            r_rmw       <= cmd_write && (cmd_mask != '0);
`endif
            r_req       <= 1'b1;
            r_state     <= ST_REQ;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_REQ: begin
          if (drp_gnt) begin
            r_den   <= 1'b1;
            r_daddr <= r_addr;
`ifdef DRP_RMW_EN
            r_dwe   <= r_write && !r_rmw;
            r_di    <= (r_write && !r_rmw) ? r_wdata : '0;
`else
            r_dwe   <= r_write;
            r_di    <= r_write ? r_wdata : '0;
`endif
            r_state <= ST_ACCESS;
          end else if (w_expired) begin
            r_req         <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
            r_state       <= ST_RESP;
          end
        end
        ST_ACCESS: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (drp_drdy) begin
`ifdef DRP_RMW_EN
            if (r_rmw) begin
              // Keep the pre-modify word for the response; write the merge.
              r_rsp_rdata <= drp_drpdo;
              r_den       <= 1'b1;
              r_dwe       <= 1'b1;
              r_di        <= (drp_drpdo & ~r_mask) | (r_wdata & r_mask);
              r_state     <= ST_ACCESS_W;
            end else
`endif
            begin
              r_rsp_rdata   <= r_write ? '0 : drp_drpdo;
              r_req         <= 1'b0;
              r_rsp_valid   <= 1'b1;
              r_rsp_timeout <= 1'b0;
              r_state       <= ST_RESP;
            end
          end else if (w_expired) begin
            r_req         <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
            r_state       <= ST_RESP;
          end
        end
`ifdef DRP_RMW_EN
        ST_ACCESS_W: begin
          r_state <= ST_WAIT_W;
        end
        ST_WAIT_W: begin
          if (drp_drdy) begin
            r_req         <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_RESP;
          end else if (w_expired) begin
            r_req         <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
            r_state       <= ST_RESP;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
            r_cmd_ready   <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drp_master_ctrl.sv
module tb_drp_master_ctrl;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW-1:0] cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_timeout;
  logic          drp_req;
  logic          drp_gnt = 1'b1;
  logic          drp_den;
  logic          drp_dwe;
  logic [AW-1:0] drp_daddr;
  logic [DW-1:0] drp_di;
  logic          mdl_drdy = 1'b0;
  logic          man_drdy = 1'b0;
  logic          drp_drdy;
  logic [DW-1:0] drp_drpdo = 16'hDEAD;

  assign drp_drdy = mdl_drdy | man_drdy;

  always #5 clk = ~clk;

  drp_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_mask    (cmd_mask),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .drp_req     (drp_req),
    .drp_gnt     (drp_gnt),
    .drp_den     (drp_den),
    .drp_dwe     (drp_dwe),
    .drp_daddr   (drp_daddr),
    .drp_di      (drp_di),
    .drp_drdy    (drp_drdy),
    .drp_drpdo   (drp_drpdo)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int lat = 1;
  int cd = 0;
  int den_cnt = 0;
  int req_hi = 0;
  int viol = 0;
  logic [DW-1:0] rd_val = '0;
  logic [AW-1:0] den_addr [8];
  logic          den_dwe  [8];
  logic [DW-1:0] den_di   [8];
  int            den_rel  [8];

  always @(posedge clk) cyc <= cyc + 1;

  // DRP slave model: answers each den with a one-cycle drdy 'lat' cycles later
  // (lat=0: never answers); drpdo carries junk whenever drdy is low.
  initial forever begin
    @(negedge clk);
    mdl_drdy  = 1'b0;
    drp_drpdo = 16'hDEAD;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mdl_drdy  = 1'b1;
        drp_drpdo = rd_val;
      end
    end
    if (drp_req) req_hi++;
    if (drp_den) begin
      den_addr[den_cnt % 8] = drp_daddr;
      den_dwe[den_cnt % 8]  = drp_dwe;
      den_di[den_cnt % 8]   = drp_di;
      den_rel[den_cnt % 8]  = cyc - acc_cyc + 1;
      den_cnt++;
      if (lat > 0) cd = lat;
    end else if (drp_dwe || (drp_di != '0)) begin
      viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns with the accept edge just passed (spec cycle 1 = first REQ cycle).
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] m);
    int g;
    g = 0;
    while (!cmd_ready && g < 50) begin
      tick;
      g++;
    end
    chk("cmd_ready_before_send", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_mask  = m;
    req_hi    = 0;
    tick;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic ack;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    int bad;

    repeat (3) tick;
    chk("reset_ctl", {cmd_ready, rsp_valid, rsp_timeout, drp_req, drp_den, drp_dwe}, 0);
    chk("reset_data", {rsp_rdata, drp_di}, 0);
    rst_n = 1'b1;
    tick;
    tick;
    chk("idle_ready", cmd_ready, 1);

    // Basic read, immediate grant, drdy one cycle after den
    lat = 1; rd_val = 16'hBEEF; d0 = den_cnt;
    send(1'b0, 16'h0051, 16'h0, 16'h0);
    wait_rsp(n);
    chk("rd_rsp_cycle", n + 1, 4);
    chk("rd_den_count", den_cnt - d0, 1);
    chk("rd_den_cycle", den_rel[d0 % 8], 2);
    chk("rd_daddr", den_addr[d0 % 8], 16'h0051);
    chk("rd_dwe", den_dwe[d0 % 8], 0);
    chk("rd_rdata", rsp_rdata, 16'hBEEF);
    chk("rd_timeout", rsp_timeout, 0);
    ack;
    chk("rd_ready_after", cmd_ready, 1);

    // Write, drdy three cycles after den
    lat = 3; rd_val = 16'h7777; d0 = den_cnt;
    send(1'b1, 16'h0010, 16'h1234, 16'h0);
    wait_rsp(n);
    chk("wr_rsp_cycle", n + 1, 6);
    chk("wr_den_count", den_cnt - d0, 1);
    chk("wr_dwe", den_dwe[d0 % 8], 1);
    chk("wr_di", den_di[d0 % 8], 16'h1234);
    chk("wr_daddr", den_addr[d0 % 8], 16'h0010);
    chk("wr_rdata", rsp_rdata, 0);
    chk("wr_timeout", rsp_timeout, 0);
    chk("wr_req_in_resp", drp_req, 0);
    ack;

    // Grant withheld: 8 cycles of req, no den, timeout
    drp_gnt = 1'b0; lat = 1; d0 = den_cnt;
    send(1'b0, 16'h0040, 16'h0, 16'h0);
    wait_rsp(n);
    chk("gto_rsp_cycle", n + 1, 9);
    chk("gto_req_cycles", req_hi, 8);
    chk("gto_no_den", den_cnt - d0, 0);
    chk("gto_timeout", rsp_timeout, 1);
    chk("gto_rdata", rsp_rdata, 0);
    ack;
    drp_gnt = 1'b1; rd_val = 16'h1111;
    send(1'b0, 16'h0041, 16'h0, 16'h0);
    wait_rsp(n);
    chk("gto_next_rdata", rsp_rdata, 16'h1111);
    chk("gto_next_timeout", rsp_timeout, 0);
    ack;

    // Grant arriving in the last allowed REQ cycle wins over the timeout
    drp_gnt = 1'b0; rd_val = 16'h2222; d0 = den_cnt;
    send(1'b0, 16'h0042, 16'h0, 16'h0);
    repeat (7) tick;
    drp_gnt = 1'b1;
    wait_rsp(n);
    chk("glast_den_cycle", den_rel[d0 % 8], 9);
    chk("glast_timeout", rsp_timeout, 0);
    chk("glast_rdata", rsp_rdata, 16'h2222);
    ack;

    // No drdy: WAIT times out
    lat = 0; d0 = den_cnt;
    send(1'b0, 16'h0043, 16'h0, 16'h0);
    wait_rsp(n);
    chk("wto_rsp_cycle", n + 1, 11);
    chk("wto_den_count", den_cnt - d0, 1);
    chk("wto_timeout", rsp_timeout, 1);
    chk("wto_rdata", rsp_rdata, 0);
    ack;

    // drdy in the last allowed WAIT cycle wins over the timeout
    lat = 8; rd_val = 16'h3333;
    send(1'b0, 16'h0045, 16'h0, 16'h0);
    wait_rsp(n);
    chk("wlast_rsp_cycle", n + 1, 11);
    chk("wlast_timeout", rsp_timeout, 0);
    chk("wlast_rdata", rsp_rdata, 16'h3333);
    ack;

    // Response back-pressure with a second command waiting
    lat = 1; rd_val = 16'h5A5A;
    send(1'b0, 16'h0022, 16'h0, 16'h0);
    wait_rsp(n);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0023;
    bad = 0; d0 = den_cnt;
    repeat (5) begin
      tick;
      if (!rsp_valid || rsp_rdata != 16'h5A5A || cmd_ready) bad++;
    end
    chk("stall_stable", bad, 0);
    chk("stall_no_den", den_cnt - d0, 0);
    rd_val = 16'h6B6B;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("stall_valid_drop", rsp_valid, 0);
    chk("stall_ready_after", cmd_ready, 1);
    tick;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    chk("stall_second_accepted", cmd_ready, 0);
    wait_rsp(n);
    chk("stall_second_daddr", den_addr[d0 % 8], 16'h0023);
    chk("stall_second_rdata", rsp_rdata, 16'h6B6B);
    ack;

    // Asynchronous reset while in WAIT
    lat = 0;
    send(1'b0, 16'h0044, 16'h0, 16'h0);
    tick;
    tick;
    chk("rst_pre_req", drp_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", {cmd_ready, rsp_valid, rsp_timeout, drp_req, drp_den, drp_dwe}, 0);
    chk("rst_async_data", {rsp_rdata, drp_daddr}, 0);
    tick;
    tick;
    rst_n = 1'b1;
    d0 = den_cnt;
    man_drdy = 1'b1;
    tick;
    tick;
    man_drdy = 1'b0;
    chk("rst_late_drdy_valid", rsp_valid, 0);
    chk("rst_late_drdy_den", den_cnt - d0, 0);
    chk("rst_ready_after", cmd_ready, 1);
    lat = 1; rd_val = 16'hC0DE;
    send(1'b0, 16'h0077, 16'h0, 16'h0);
    wait_rsp(n);
    chk("rst_next_cycle", n + 1, 4);
    chk("rst_next_rdata", rsp_rdata, 16'hC0DE);
    chk("rst_next_timeout", rsp_timeout, 0);
    ack;

`ifdef DRP_RMW_EN
    // Masked write as read-modify-write
    lat = 1; rd_val = 16'hFF00; d0 = den_cnt;
    send(1'b1, 16'h0060, 16'h00AA, 16'h00FF);
    wait_rsp(n);
    chk("rmw_den_count", den_cnt - d0, 2);
    chk("rmw_rd_dwe", den_dwe[d0 % 8], 0);
    chk("rmw_wr_dwe", den_dwe[(d0 + 1) % 8], 1);
    chk("rmw_wr_di", den_di[(d0 + 1) % 8], 16'hFFAA);
    chk("rmw_wr_daddr", den_addr[(d0 + 1) % 8], 16'h0060);
    chk("rmw_req_cycles", req_hi, n + 1 - 1);
    chk("rmw_rsp_cycle", n + 1, 6);
    chk("rmw_rdata", rsp_rdata, 16'hFF00);
    chk("rmw_timeout", rsp_timeout, 0);
    ack;
`else
    // Without RMW support the mask is ignored: plain single write
    lat = 1; rd_val = 16'h9999; d0 = den_cnt;
    send(1'b1, 16'h0012, 16'h5678, 16'h00FF);
    wait_rsp(n);
    chk("mwr_den_count", den_cnt - d0, 1);
    chk("mwr_dwe", den_dwe[d0 % 8], 1);
    chk("mwr_di", den_di[d0 % 8], 16'h5678);
    chk("mwr_rdata", rsp_rdata, 0);
    ack;
`endif

    chk("strobes_quiet_outside_access", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
